// File: rtl/bb_pkg.sv
// Shared types and sizing helpers for the black-box truth-table prober.
package bb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      FIN   = 2'd2
   } state_t;

   // Sizing for the default 3-input / 1-output configuration.
   localparam int N_IN_DEF  = 3;
   localparam int N_OUT_DEF = 1;
   localparam int NVEC      = 1 << N_IN_DEF;
   localparam int TBL_W     = N_OUT_DEF * NVEC;

   // Number of input vectors in a sweep.
   function automatic int nvec_f(input int n_in);
      return 1 << n_in;
   endfunction

   // Total truth-table width.
   function automatic int tbl_w_f(input int n_in, input int n_out);
      return n_out * (1 << n_in);
   endfunction

   // LSB position of the minterm-count field for output o.
   function automatic int cnt_off(input int o, input int n_in);
      return o * (n_in + 1);
   endfunction

endpackage

// File: rtl/bb_prober_if.sv
// Handshake, black-box and result signals of the prober, grouped as one bundle.
interface bb_prober_if
   import bb_pkg::*;
#(
   parameter int N_IN  = 3,
   parameter int N_OUT = 1
);
   localparam int TW = tbl_w_f(N_IN, N_OUT);
   localparam int CW = N_IN + 1;

   logic                  start;
   logic                  abort;
   logic [TW-1:0]         expect_tbl;
   logic [N_OUT-1:0]      resp;
   logic [N_IN-1:0]       probe_vec;
   logic                  busy;
   logic                  done;
   logic                  result_valid;
   logic [TW-1:0]         truth_tbl;
   logic [N_OUT*CW-1:0]   ones_cnt;
   logic                  mismatch;
   logic [N_IN-1:0]       first_bad;

   // Prober side.
   modport master (
      input  start, abort, expect_tbl, resp,
      output probe_vec, busy, done, result_valid, truth_tbl, ones_cnt, mismatch, first_bad
   );

   // Environment side: issues requests, hosts the black box, reads results.
   modport slave (
      output start, abort, expect_tbl, resp,
      input  probe_vec, busy, done, result_valid, truth_tbl, ones_cnt, mismatch, first_bad
   );
endinterface

// File: rtl/bb_settle_timer.sv
// Loadable down-counter that holds each probe vector for SETTLE extra cycles.
module bb_settle_timer #(
   parameter int SETTLE = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic en_i,
   output logic zero_o
);
   localparam int W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam logic [W-1:0] RELOAD = W'(SETTLE);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: reload wins over decrement; never goes below zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = RELOAD;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/bb_prober.sv
// Sweeps every input pattern into a combinational black box, builds its truth
// table, counts minterms per output and compares against an expected table.
module bb_prober
   import bb_pkg::*;
#(
   parameter int N_IN   = 3,
   parameter int N_OUT  = 1,
   parameter int SETTLE = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   bb_prober_if.master  bus
);
   localparam int NV = nvec_f(N_IN);
   localparam int TW = tbl_w_f(N_IN, N_OUT);
   localparam int CW = N_IN + 1;
   localparam logic [N_IN-1:0] LAST = N_IN'(NV - 1);

   state_t              state_q, state_d;
   logic [N_IN-1:0]     idx_q, idx_d;
   logic [N_IN-1:0]     first_bad_q, first_bad_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                rv_q, rv_d;
   logic                mismatch_q, mismatch_d;
   logic                seen_q, seen_d;
   logic [TW-1:0]       truth_q, truth_d, truth_smp;
   logic [TW-1:0]       exp_q, exp_d;
   logic [N_OUT*CW-1:0] ones_q, ones_d, ones_smp;
   logic [N_OUT-1:0]    diff;

   logic accept, sample, last, tmr_load, tmr_en, tmr_zero;

   assign accept   = (state_q == IDLE)  && bus.start && !bus.abort;
   assign sample   = (state_q == DRIVE) && !bus.abort && tmr_zero;
   assign last     = (idx_q == LAST);
   assign tmr_load = accept || (sample && !last);
   assign tmr_en   = (state_q == DRIVE) && !bus.abort && !tmr_zero;

   bb_settle_timer #(.SETTLE(SETTLE)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (tmr_load),
      .en_i   (tmr_en),
      .zero_o (tmr_zero)
   );

   // Per-output sample path: the table row with the current response merged
   // in, the incremented minterm count and the compare against the expected bit.
   // Rows are cleared at start and each bit is written once, so OR-merge suffices.
   generate
      for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
         logic [NV-1:0] exp_row, truth_row, hit;
         assign exp_row   = exp_q[gi*NV +: NV];
         assign truth_row = truth_q[gi*NV +: NV];
         assign hit       = NV'(bus.resp[gi]) << idx_q;
         assign truth_smp[gi*NV +: NV] = truth_row | hit;
         assign ones_smp[cnt_off(gi, N_IN) +: CW] =
            ones_q[cnt_off(gi, N_IN) +: CW] + CW'(bus.resp[gi]);
         assign diff[gi] = bus.resp[gi] ^ exp_row[idx_q];
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort always returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = DRIVE;
         DRIVE: begin
            if (bus.abort)          state_d = IDLE;
            else if (sample && last) state_d = FIN;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output/datapath next values; every registered output reflects the state being entered.
   always_comb begin
      idx_d       = idx_q;
      first_bad_d = first_bad_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      rv_d        = rv_q;
      mismatch_d  = mismatch_q;
      seen_d      = seen_q;
      truth_d     = truth_q;
      exp_d       = exp_q;
      ones_d      = ones_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               idx_d       = '0;
               first_bad_d = '0;
               busy_d      = 1'b1;
               rv_d        = 1'b0;
               mismatch_d  = 1'b0;
               seen_d      = 1'b0;
               truth_d     = '0;
               ones_d      = '0;
               exp_d       = bus.expect_tbl;
            end
         end
         DRIVE: begin
            if (bus.abort) begin
               busy_d     = 1'b0;
               rv_d       = 1'b0;
               mismatch_d = 1'b0;
            end else if (sample) begin
               truth_d = truth_smp;
               ones_d  = ones_smp;
               if ((diff != '0) && !seen_q) begin
                  seen_d      = 1'b1;
                  first_bad_d = idx_q;
               end
               if (last) begin
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
                  rv_d       = 1'b1;
                  mismatch_d = seen_q || (diff != '0);
               end else begin
                  idx_d = idx_q + N_IN'(1);
               end
            end
         end
         FIN: begin
            if (bus.abort) begin
               rv_d       = 1'b0;
               mismatch_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         first_bad_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rv_q        <= 1'b0;
         mismatch_q  <= 1'b0;
         seen_q      <= 1'b0;
         truth_q     <= '0;
         exp_q       <= '0;
         ones_q      <= '0;
      end else begin
         idx_q       <= idx_d;
         first_bad_q <= first_bad_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rv_q        <= rv_d;
         mismatch_q  <= mismatch_d;
         seen_q      <= seen_d;
         truth_q     <= truth_d;
         exp_q       <= exp_d;
         ones_q      <= ones_d;
      end
   end

   assign bus.probe_vec    = idx_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.result_valid = rv_q;
   assign bus.truth_tbl    = truth_q;
   assign bus.ones_cnt     = ones_q;
   assign bus.mismatch     = mismatch_q;
   assign bus.first_bad    = first_bad_q;
endmodule
